alu_share_sequencer: RTL
========================

Name: alu_share_sequencer

Overview:
- Shares the single combinational ALU between two requesters (req0, req1) using round-robin arbitration.
- Registers the granted operation onto the ALU inputs, captures Y/N/Z/C/V, and returns the result with a valid/ready handshake.
- Provides a 64-bit signed multiply pseudo-op that it expands into two ALU passes: MULT LO (6'b011001), then MULT HI (6'b011010).
- Sits between the decode/issue logic and the ALU.

Parameters:
- DATA_W, 32, operand/result width; must match the ALU.
- MULT_FUNC, 6'b011000, pseudo-op code selecting the two-pass 64-bit multiply.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  2  per-requester request valid; bit i = requester i.
- req_ready  out  2  per-requester accept; combinational, at most one bit high.
- req0_func, req1_func  in  6  ALU function code.
- req0_a, req1_a, req0_b, req1_b  in  DATA_W  operands A and B.
- alu_func  out  6  registered function code driven to the ALU.
- alu_a, alu_b  out  DATA_W  registered operands driven to the ALU.
- alu_y  in  DATA_W  ALU result.
- alu_n, alu_z, alu_c, alu_v  in  1  ALU flags.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accept.
- rsp_id  out  1  index of the requester that owns the response.
- rsp_y  out  DATA_W  result; LO word for MULT_FUNC.
- rsp_hi  out  DATA_W  HI word for MULT_FUNC; 0 otherwise.
- rsp_flags  out  4  {N,Z,C,V}.
- rsp_err  out  1  unsupported function code.
- busy  out  1  high in every state except IDLE.

Behaviour:
- States: IDLE, EXEC, EXEC_LO, EXEC_HI, RESP.
- Supported codes: 100000, 100001, 100011, 001001, 011001, 011010, 000011, 000010, 000001, 010110, 111000, 111100, 111110, 111001, 110110, 101110, 100101, plus MULT_FUNC. Any other code is unsupported.
- Reset (async, any state, including mid-multiply):
  - state=IDLE, rr_ptr=0, in-flight op discarded, no response emitted.
  - alu_func, alu_a, alu_b = 0.
  - rsp_* = 0; rsp_valid=0, busy=0, req_ready=0.
- Arbitration (IDLE only):
  - grant = the valid requester; if both are valid, grant = rr_ptr.
  - req_ready[grant]=1 in that cycle only; req_ready=0 in all other states.
  - On accept: rr_ptr <= ~grant; rsp_id <= grant.
- Accept, normal code: alu_func/a/b <= request; -> EXEC.
- Accept, MULT_FUNC: alu_func <= 011001, alu_a/b <= operands; -> EXEC_LO.
- Accept, unsupported code:
  - No ALU issue; alu_* hold their previous values.
  - rsp_y=0, rsp_hi=0, rsp_flags=0, rsp_err=1; -> RESP.
- EXEC: rsp_y <= alu_y; rsp_flags <= {n,z,c,v}; rsp_hi <= 0; rsp_err <= 0; -> RESP.
- EXEC_LO: rsp_y <= alu_y; alu_func <= 011010; -> EXEC_HI.
- EXEC_HI: rsp_hi <= alu_y; rsp_flags <= {n,z,c,v} from the HI pass; rsp_err <= 0; -> RESP.
- RESP:
  - rsp_valid=1; all rsp_* stable until rsp_ready=1.
  - On rsp_valid & rsp_ready -> IDLE; a new grant is possible the following cycle.
- Latency from the accept edge T to rsp_valid:
  - normal code: T+2;
  - MULT_FUNC: T+3;
  - unsupported code: T+1.
- Throughput: one op in flight. Maximum issue rate is one op per 3 cycles for normal codes with rsp_ready tied high.
- req_valid may drop without acceptance; the sequencer takes no action.
- alu_a/alu_b hold their values after an op completes; alu_func holds its last value.

Test Plan:
- req0: func 100000, A=0x7FFFFFFF, B=1, rsp_ready=1 -> rsp_valid 2 cycles after accept; rsp_y=0x80000000, flags N=1 Z=0 C=0 V=1, rsp_id=0, rsp_err=0.
- req1: func MULT_FUNC, A=0x00010000, B=0x00010000 -> alu_func 011001 then 011010; rsp at T+3 with rsp_y=0, rsp_hi=0x00000001, N=0, Z=0.
- Both requesters valid continuously, each with ADD 1+1, out of reset -> grant order 0,1,0,1; rsp_id alternates; each rsp_y=2.
- req0: func 6'b111111 -> rsp_valid at T+1; rsp_err=1, rsp_y=0, rsp_flags=0; alu_func unchanged.
- req0: func 100101, A=0xF0, B=0x0F, rsp_ready held low 3 cycles -> rsp_valid stays 1, rsp_y=0xFF stable; req_ready=0 throughout; returns to IDLE on the cycle after rsp_ready=1.
- Reset asserted during EXEC_HI of a multiply -> next cycle state=IDLE, all outputs 0; no response for the aborted op; a following ADD 2+3 returns rsp_y=5.

Source files
------------

// File: rtl/alu_share_sequencer.sv
// alu_share_sequencer: round-robin front end that shares one combinational ALU
// between two requesters. It registers the granted operation onto the ALU
// inputs, captures the result and flags, and returns them over a valid/ready
// response channel. A multiply pseudo-op is expanded into LO and HI ALU passes.
module alu_share_sequencer #(
  parameter int         DATA_W    = 32,
  parameter logic [5:0] MULT_FUNC = 6'b011000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [5:0]        req0_func,
  input  logic [5:0]        req1_func,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [DATA_W-1:0] req1_b,
  output logic [5:0]        alu_func,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_y,
  input  logic              alu_n,
  input  logic              alu_z,
  input  logic              alu_c,
  input  logic              alu_v,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_y,
  output logic [DATA_W-1:0] rsp_hi,
  output logic [3:0]        rsp_flags,
  output logic              rsp_err,
  output logic              busy
);

  // The two real ALU codes the multiply pseudo-op is split into.
  localparam logic [5:0] FUNC_MULT_LO = 6'b011001;
  localparam logic [5:0] FUNC_MULT_HI = 6'b011010;

  typedef enum logic [2:0] {
    IDLE,
    EXEC,
    EXEC_LO,
    EXEC_HI,
    RESP
  } state_t;

  state_t state;
  state_t state_next;

  logic              rr_ptr;
  logic              grant;
  logic              accept;
  logic [5:0]        grant_func;
  logic [DATA_W-1:0] grant_a;
  logic [DATA_W-1:0] grant_b;
  logic              grant_mult;
  logic              grant_supported;

  // Codes the ALU actually implements; anything else is answered with rsp_err.
  function automatic logic is_supported(input logic [5:0] f);
    case (f)
      6'b100000, 6'b100001, 6'b100011, 6'b001001, 6'b011001, 6'b011010,
      6'b000011, 6'b000010, 6'b000001, 6'b010110, 6'b111000, 6'b111100,
      6'b111110, 6'b111001, 6'b110110, 6'b101110, 6'b100101: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Arbitration: a lone requester wins, rr_ptr breaks ties; ready only in IDLE.
  always_comb begin
    grant           = (req_valid == 2'b11) ? rr_ptr : req_valid[1];
    accept          = (state == IDLE) && (|req_valid) && !reset;
    req_ready       = 2'b00;
    if (accept) begin
      req_ready[grant] = 1'b1;
    end
    grant_func      = grant ? req1_func : req0_func;
    grant_a         = grant ? req1_a : req0_a;
    grant_b         = grant ? req1_b : req0_b;
    grant_mult      = (grant_func == MULT_FUNC);
    grant_supported = grant_mult || is_supported(grant_func);
  end

  // Next-state logic for the single-op-in-flight sequencer.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (grant_mult) begin
            state_next = EXEC_LO;
          end else if (grant_supported) begin
            state_next = EXEC;
          end else begin
            state_next = RESP;
          end
        end
      end
      EXEC:    state_next = RESP;
      EXEC_LO: state_next = EXEC_HI;
      EXEC_HI: state_next = RESP;
      RESP: begin
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register; reset abandons any op in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Datapath: issue to the ALU, capture results, track round-robin pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr    <= 1'b0;
      alu_func  <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      rsp_id    <= 1'b0;
      rsp_y     <= '0;
      rsp_hi    <= '0;
      rsp_flags <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            rr_ptr <= ~grant;
            rsp_id <= grant;
            if (grant_mult) begin
              alu_func <= FUNC_MULT_LO;
              alu_a    <= grant_a;
              alu_b    <= grant_b;
            end else if (grant_supported) begin
              alu_func <= grant_func;
              alu_a    <= grant_a;
              alu_b    <= grant_b;
            end else begin
              rsp_y     <= '0;
              rsp_hi    <= '0;
              rsp_flags <= '0;
              rsp_err   <= 1'b1;
            end
          end
        end
        EXEC: begin
          rsp_y     <= alu_y;
          rsp_hi    <= '0;
          rsp_flags <= {alu_n, alu_z, alu_c, alu_v};
          rsp_err   <= 1'b0;
        end
        EXEC_LO: begin
          rsp_y    <= alu_y;
          alu_func <= FUNC_MULT_HI;
        end
        EXEC_HI: begin
          rsp_hi    <= alu_y;
          rsp_flags <= {alu_n, alu_z, alu_c, alu_v};
          rsp_err   <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);

endmodule
